// File: rtl/cq_viola_oci_dct_pkg.sv
// ---------------------------------------------------------------------------
// cq_viola_oci_dct_pkg
//
// Shared definitions for the OCI data-capture-trace (DCT) path. Both the
// packer (writer) and the unpacker (reader) import this package so the
// frame geometry and state encoding stay in one place.
//
// Contents:
//   FIELD_W  - bits per trace frame
//   FIELDS   - frames packed into one DCT word
//   COUNT_W  - width of the per-word frame count
//   DCT_W    - packed DCT word width (FIELD_W * FIELDS)
//   dct_state_e      - reader FSM encoding
//   clamp_count()    - limit a frame count to FIELDS
//   count_overflows()- true when a frame count exceeds FIELDS
// ---------------------------------------------------------------------------
package cq_viola_oci_dct_pkg;

  localparam int FIELD_W = 3;
  localparam int FIELDS  = 10;
  localparam int COUNT_W = 4;
  localparam int DCT_W   = FIELD_W * FIELDS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ENDED = 2'd2
  } dct_state_e;

  // A count above FIELDS still delivers a full word; the excess is flagged
  // separately rather than wrapping or being dropped.
  function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] cnt);
    logic [COUNT_W-1:0] res;
    if (cnt > COUNT_W'(FIELDS)) begin
      res = COUNT_W'(FIELDS);
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  function automatic logic count_overflows(input logic [COUNT_W-1:0] cnt);
    return (cnt > COUNT_W'(FIELDS));
  endfunction

endpackage

// File: rtl/cq_viola_nios2_e_oci_dct_reader.sv
// ---------------------------------------------------------------------------
// cq_viola_nios2_e_oci_dct_reader
//
// Consumer end of the OCI DCT trace path. Accepts packed DCT words (frame 0
// in the low bits) with a frame count, and emits the frames one at a time
// under a valid/ready handshake. Also owns the end-of-test protocol: once
// test_ending has been seen, every held frame is drained and then
// test_has_ended rises and stays high until reset.
//
// Ports:
//   clk_i            - single clock
//   reset_i          - synchronous, active-high reset
//   dct_buffer_i     - packed frames, frame k in bits [3k+2:3k]
//   dct_count_i      - number of valid frames, counted from frame 0 upward
//   dct_valid_i      - dct_buffer_i / dct_count_i are valid
//   dct_ready_o      - reader accepts a word this cycle
//   frame_data_o     - current trace frame
//   frame_valid_o    - frame_data_o is valid
//   frame_ready_i    - sink takes the frame this cycle
//   frame_last_o     - current frame is the last of its word
//   test_ending_i    - level; producer has stopped issuing words
//   test_has_ended_o - sticky; drain complete after test_ending
//   overflow_err_o   - sticky; a word arrived with count > FIELDS
// ---------------------------------------------------------------------------
module cq_viola_nios2_e_oci_dct_reader
  import cq_viola_oci_dct_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [DCT_W-1:0]   dct_buffer_i,
  input  logic [COUNT_W-1:0] dct_count_i,
  input  logic               dct_valid_i,
  output logic               dct_ready_o,
  output logic [FIELD_W-1:0] frame_data_o,
  output logic               frame_valid_o,
  input  logic               frame_ready_i,
  output logic               frame_last_o,
  input  logic               test_ending_i,
  output logic               test_has_ended_o,
  output logic               overflow_err_o
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  dct_state_e         state_q,    state_d;
  logic [DCT_W-1:0]   shreg_q,    shreg_d;
  logic [COUNT_W-1:0] rem_q,      rem_d;
  logic               end_req_q,  end_req_d;
  logic               overflow_q, overflow_d;

  // Combinational helpers
  logic               dct_ready_s;
  logic               is_last_s;
  logic               accept_s;
  logic [COUNT_W-1:0] load_cnt_s;
  logic               load_word_s;

  // rem_q == 1 only ever holds in SHIFT, but qualify on state so a stale
  // count can never show up as frame_last outside a live word.
  assign is_last_s   = (state_q == ST_SHIFT) && (rem_q == COUNT_W'(1));
  assign accept_s    = dct_valid_i & dct_ready_s;
  assign load_cnt_s  = clamp_count(dct_count_i);
  // A zero-count word is consumed but never loaded, so the FSM stays put.
  assign load_word_s = accept_s && (load_cnt_s != COUNT_W'(0));

  // State register and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      rem_q      <= '0;
      end_req_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      rem_q      <= rem_d;
      end_req_q  <= end_req_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic: FSM transitions, shift register and frame counter
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    rem_d      = rem_q;
    end_req_d  = end_req_q | test_ending_i;
    overflow_d = overflow_q | (accept_s & count_overflows(dct_count_i));

    case (state_q)
      ST_IDLE: begin
        if (load_word_s) begin
          shreg_d = dct_buffer_i;
          rem_d   = load_cnt_s;
          state_d = ST_SHIFT;
        end else if (!accept_s && end_req_q) begin
          // Only leave for ENDED on a cycle with no accept, so a word
          // offered alongside test_ending is processed first.
          state_d = ST_ENDED;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (frame_ready_i) begin
          if (rem_q == COUNT_W'(1)) begin
            if (load_word_s) begin
              // Next word accepted on the same cycle the last frame goes,
              // so the sink sees no bubble between words.
              shreg_d = dct_buffer_i;
              rem_d   = load_cnt_s;
              state_d = ST_SHIFT;
            end else begin
              shreg_d = shreg_q >> FIELD_W;
              rem_d   = rem_q - COUNT_W'(1);
              state_d = ST_IDLE;
            end
          end else begin
            shreg_d = shreg_q >> FIELD_W;
            rem_d   = rem_q - COUNT_W'(1);
            state_d = ST_SHIFT;
          end
        end else begin
          // Backpressure: hold frame and count untouched.
          state_d = ST_SHIFT;
        end
      end

      ST_ENDED: begin
        state_d = ST_ENDED;
      end

      default: begin
        // Unused encoding: recover to a clean idle state.
        state_d = ST_IDLE;
        shreg_d = '0;
        rem_d   = '0;
      end
    endcase
  end

  // Output decode from the current state
  always_comb begin
    dct_ready_s      = 1'b0;
    frame_valid_o    = 1'b0;
    frame_data_o     = {FIELD_W{1'b0}};
    frame_last_o     = 1'b0;
    test_has_ended_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // test_has_ended is never set while idle, so ready is always 1 here.
        dct_ready_s = 1'b1;
      end

      ST_SHIFT: begin
        frame_valid_o = 1'b1;
        frame_data_o  = shreg_q[FIELD_W-1:0];
        frame_last_o  = is_last_s;
        // Deliberate combinational frame_ready -> dct_ready path.
        dct_ready_s   = is_last_s & frame_ready_i;
      end

      ST_ENDED: begin
        test_has_ended_o = 1'b1;
      end

      default: begin
        dct_ready_s = 1'b0;
      end
    endcase
  end

  assign dct_ready_o    = dct_ready_s;
  assign overflow_err_o = overflow_q;

endmodule

// File: tb/tb_cq_viola_nios2_e_oci_dct_reader.sv
// ---------------------------------------------------------------------------
// tb_cq_viola_nios2_e_oci_dct_reader
//
// Directed bench for the DCT reader. Inputs change 1ns after each rising
// edge; outputs are compared on the falling edge as one packed vector:
//   {dct_ready, frame_valid, frame_last, frame_data[2:0], test_has_ended,
//    overflow_err}
// ---------------------------------------------------------------------------
module tb_cq_viola_nios2_e_oci_dct_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready;
  logic [2:0]  frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        frame_last;
  logic        test_ending;
  logic        test_has_ended;
  logic        overflow_err;

  logic [7:0]  obs;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign obs = {dct_ready, frame_valid, frame_last, frame_data, test_has_ended, overflow_err};

  cq_viola_nios2_e_oci_dct_reader dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .dct_buffer_i     (dct_buffer),
    .dct_count_i      (dct_count),
    .dct_valid_i      (dct_valid),
    .dct_ready_o      (dct_ready),
    .frame_data_o     (frame_data),
    .frame_valid_o    (frame_valid),
    .frame_ready_i    (frame_ready),
    .frame_last_o     (frame_last),
    .test_ending_i    (test_ending),
    .test_has_ended_o (test_has_ended),
    .overflow_err_o   (overflow_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [29:0] b, input logic [3:0] c, input logic fr);
    dct_valid   = v;
    dct_buffer  = b;
    dct_count   = c;
    frame_ready = fr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    test_ending = 1'b0;
    drive(1'b0, 30'd0, 4'd0, 1'b0);
    step();
    step();
    @(negedge clk);
    checks++;
    if (obs !== 8'b1_0_0_000_0_0) begin
      failures++;
      $display("FAIL reset_held obs=%b exp=%b", obs, 8'b1_0_0_000_0_0);
    end
    step();
    reset = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (obs !== 8'b1_0_0_000_0_0) begin
      failures++;
      $display("FAIL reset_released obs=%b exp=%b", obs, 8'b1_0_0_000_0_0);
    end
    step();
  endtask

  task automatic test_single_word();
    logic [7:0] e [5];
    e = '{8'b1_0_0_000_0_0, 8'b0_1_0_001_0_0, 8'b0_1_0_010_0_0,
          8'b1_1_1_011_0_0, 8'b1_0_0_000_0_0};
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(1'b1, 30'h0000_00D1, 4'd3, 1'b1);
      else        drive(1'b0, 30'd0, 4'd0, 1'b1);
      @(negedge clk);
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL single_word cyc%0d obs=%b exp=%b", i, obs, e[i]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  e  [6];
    logic        v  [6];
    logic [29:0] b  [6];
    logic [3:0]  c  [6];
    logic        fr [6];
    e  = '{8'b1_0_0_000_0_0, 8'b0_1_0_101_0_0, 8'b0_1_0_101_0_0,
           8'b1_1_1_110_0_0, 8'b1_1_1_111_0_0, 8'b1_0_0_000_0_0};
    v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    b  = '{30'h35, 30'h7, 30'h7, 30'h7, 30'h0, 30'h0};
    c  = '{4'd2, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0};
    fr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(v[i], b[i], c[i], fr[i]);
      @(negedge clk);
      checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL back_to_back cyc%0d obs=%b exp=%b", i, obs, e[i]);
      end
      step();
    end
  endtask

  task automatic test_counts();
    logic [29:0] b;
    logic [7:0]  exp;
    // Zero-count word: consumed silently.
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive(1'b1, 30'h3FFF_FFFF, 4'd0, 1'b1);
      else        drive(1'b0, 30'd0, 4'd0, 1'b1);
      @(negedge clk);
      checks++;
      if (obs !== 8'b1_0_0_000_0_0) begin
        failures++;
        $display("FAIL count_zero cyc%0d obs=%b exp=%b", i, obs, 8'b1_0_0_000_0_0);
      end
      step();
    end
    // Count 15: clamped to ten frames of 4, overflow flagged and sticky.
    b = '0;
    for (int k = 0; k < 10; k++) b[3*k +: 3] = 3'd4;
    for (int i = 0; i < 13; i++) begin
      if (i == 0) drive(1'b1, b, 4'd15, 1'b1);
      else        drive(1'b0, 30'd0, 4'd0, 1'b1);
      if (i == 0)       exp = 8'b1_0_0_000_0_0;
      else if (i <= 10) exp = {(i == 10), 1'b1, (i == 10), 3'd4, 1'b0, 1'b1};
      else              exp = 8'b1_0_0_000_0_1;
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL count_overflow cyc%0d obs=%b exp=%b", i, obs, exp);
      end
      step();
    end
  endtask

  task automatic test_end_during_shift();
    logic [29:0] b;
    logic [7:0]  exp;
    reset = 1'b1;
    drive(1'b0, 30'd0, 4'd0, 1'b0);
    step();
    reset = 1'b0;
    b = '0;
    for (int k = 0; k < 10; k++) b[3*k +: 3] = 3'(k + 1);
    for (int i = 0; i < 14; i++) begin
      if (i == 0)       drive(1'b1, b, 4'd10, 1'b1);
      else if (i >= 12) drive(1'b1, 30'h1, 4'd1, 1'b1);
      else              drive(1'b0, 30'd0, 4'd0, 1'b1);
      test_ending = (i == 3);
      if (i == 0)       exp = 8'b1_0_0_000_0_0;
      else if (i <= 10) exp = {(i == 10), 1'b1, (i == 10), 3'(i), 1'b0, 1'b0};
      else if (i == 11) exp = 8'b1_0_0_000_0_0;
      else              exp = 8'b0_0_0_000_1_0;
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL end_during_shift cyc%0d obs=%b exp=%b", i, obs, exp);
      end
      step();
    end
    test_ending = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [29:0] b;
    logic [7:0]  exp;
    reset = 1'b1;
    drive(1'b0, 30'd0, 4'd0, 1'b0);
    step();
    reset = 1'b0;
    b = '0;
    for (int k = 0; k < 10; k++) b[3*k +: 3] = 3'(k + 1);
    for (int i = 0; i < 10; i++) begin
      reset = (i == 5);
      if (i == 0)      drive(1'b1, b, 4'd15, 1'b1);
      else if (i == 7) drive(1'b1, 30'h3FFF_FFFD, 4'd1, 1'b1);
      else             drive(1'b0, 30'd0, 4'd0, 1'b1);
      if (i == 0)      exp = 8'b1_0_0_000_0_0;
      else if (i <= 5) exp = {1'b0, 1'b1, 1'b0, 3'(i), 1'b0, 1'b1};
      else if (i == 8) exp = 8'b1_1_1_101_0_0;
      else             exp = 8'b1_0_0_000_0_0;
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL reset_mid cyc%0d obs=%b exp=%b", i, obs, exp);
      end
      step();
    end
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_counts();
    test_end_during_shift();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cq_viola_nios2_e_oci_dct_reader.md
Name: cq_viola_nios2_e_oci_dct_reader

Overview:
- Consumer end of the OCI data-capture-trace (DCT) path. Accepts packed 30-bit DCT words, each tagged with a field count, and unpacks them into a serial stream of 3-bit trace frames under a valid/ready handshake.
- Owns the end-of-test protocol: when test_ending is seen, it drains all held frames, then raises test_has_ended.
- Sits between the OCI trace capture logic and the trace sink (simulation monitor or off-chip trace port).

Parameters:
- FIELD_W, 3, bits per trace frame
- FIELDS, 10, frames per DCT word; dct_buffer width = FIELD_W*FIELDS = 30
- COUNT_W, 4, width of dct_count

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- dct_buffer  in  30  packed frames; frame 0 in bits [2:0], frame k in bits [3k+2:3k]
- dct_count  in  4  number of valid frames in dct_buffer, taken from frame 0 upward
- dct_valid  in  1  dct_buffer/dct_count are valid
- dct_ready  out  1  reader can accept a word this cycle
- frame_data  out  3  current trace frame
- frame_valid  out  1  frame_data is valid
- frame_ready  in  1  sink accepts the frame this cycle
- frame_last  out  1  current frame is the last frame of its word
- test_ending  in  1  level; producer has stopped issuing words
- test_has_ended  out  1  sticky; everything has been drained after test_ending
- overflow_err  out  1  sticky; a word arrived with dct_count > FIELDS

Behaviour:
- Reset values: all outputs 0, except dct_ready = 1 (state IDLE). The shift register, remaining counter and sticky flags are all cleared.
- Reset asserted mid-word: the held frames are discarded with no further output. The next cycle after reset deasserts is IDLE.
- Word accept occurs when dct_valid & dct_ready. Handling by count:
  - cnt = min(dct_count, FIELDS).
  - dct_count > FIELDS: set overflow_err and process 10 frames.
  - cnt = 0: word consumed, nothing emitted, state stays IDLE.
- States and transitions:
  - IDLE: dct_ready = !test_has_ended. On accept with cnt > 0, load shreg = dct_buffer and rem = cnt, then go to SHIFT.
  - SHIFT: frame_valid = 1, frame_data = shreg[2:0], frame_last = (rem == 1).
    - On frame_ready: shreg >>= 3 (zero fill), rem -= 1.
    - When the last frame is taken: go to IDLE, unless a new word is accepted the same cycle.
  - ENDED: terminal until reset. test_has_ended = 1, dct_ready = 0, frame_valid = 0.
- Back-to-back: in SHIFT, dct_ready = frame_last & frame_ready, so a new word can be accepted in the same cycle the last frame is taken, giving no bubble. This is a combinational frame_ready -> dct_ready path and is permitted.
- Latency: a word accepted in cycle N has its first frame valid in cycle N+1. With frame_ready held high, the word occupies N+1 .. N+cnt.
- Output stability: frame_data, frame_valid and frame_last hold steady while frame_valid & !frame_ready. frame_valid never drops without a handshake.
- End of test:
  - test_ending is sampled every cycle into a sticky end_req.
  - Transition to ENDED happens from IDLE when end_req = 1 and no accept occurs that cycle. test_has_ended rises one cycle later (registered).
  - If test_ending arrives while in SHIFT, the remaining frames are drained first, then ENDED.
  - If dct_valid and test_ending are both high in IDLE, the word is accepted and processed first.
- rem is 4 bits and never underflows; it is decremented only in SHIFT with rem >= 1.

Decomposition:
- Shared package cq_viola_oci_dct_pkg holds FIELD_W, FIELDS, COUNT_W, DCT_W = 30 and the state encoding (IDLE = 2'd0, SHIFT = 2'd1, ENDED = 2'd2). The matching OCI DCT writer/packer shares this package.
- No sub-module. The shift register, counter and FSM are a single block.

Test Plan:
- Single word, frames 1..3: reset, then dct_buffer = 30'h0000_00D1 (frames 1,2,3), count = 3, frame_ready = 1 → frame_data 1, 2, 3 in cycles N+1..N+3, frame_last only on the 3; dct_ready low during N+1..N+2 and high at N+3.
- Back-to-back with backpressure: word A = {count 2, frames 5,6}, word B = {count 1, frame 7} offered continuously; frame_ready low on the first SHIFT cycle → 5 is held for 2 cycles, then 6, then B accepted in the same cycle 6 is taken, then 7 with no idle cycle.
- Count edge cases: count = 0 → no frame_valid, dct_ready stays 1. count = 15 with all frames = 3'h4 → ten frames of 4 emitted, overflow_err = 1 and sticky.
- End during shift: 10-frame word, test_ending pulsed at the 3rd frame → all 10 frames emitted, test_has_ended rises 2 cycles after the last handshake (1 cycle to IDLE, 1 cycle registered), dct_ready = 0 thereafter.
- Reset mid-operation: reset asserted after 4 of 10 frames → next cycle frame_valid = 0, test_has_ended = 0, overflow_err = 0, dct_ready = 1; a new word with count 1 is then emitted correctly.
